// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//
// Purpose:
//   Shared constants for the VGA raster timing generator. Holds the standard
//   640x480@60 timing (visible area, porches, sync widths and the derived
//   totals), the default coordinate width, and a small helper that converts a
//   sync window flag into the driven pin level.
//
// Contents:
//   VGA_H_* / VGA_V_*   horizontal / vertical timing in pixels / lines
//   VGA_H_TOTAL         pixels per line including blanking (800)
//   VGA_V_TOTAL         lines per frame including blanking (525)
//   VGA_CW              default counter / coordinate width (10 bits)
//   syncLevel()         window flag -> output level for a given polarity
// -----------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixels.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Derived totals for the standard mode.
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // 10 bits covers both 800 and 525.
  localparam int VGA_CW = 10;

  // With negative polarity the pin idles high and pulses low, so the level is
  // simply the window flag inverted when negPol is set.
  function automatic logic syncLevel(input logic inWindow, input logic negPol);
    return inWindow ^ negPol;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Purpose:
//   Modulo-N up counter with an advance qualifier. Counts 0..N-1 and returns
//   to 0 by explicit compare, so it never depends on 2^W overflow. Used twice
//   by vga_timing_gen: once per pixel and once per line.
//
// Parameters:
//   N      modulus (number of distinct counter values), N <= 2^W
//   W      counter width in bits
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears the count to 0
//   inc    in   advance the count on this clock edge
//   wrap   out  high while the count sits at its last value (N-1)
//   cnt    out  current count, 0..N-1
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic         wrap,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;
  logic         w_atLast;

  assign w_atLast = (r_cnt == LAST);

  // The count moves only when inc is set; at the last value it returns to 0
  // in the same edge, so no out-of-range value is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc) begin
      if (w_atLast) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

  // wrap is a level decode of the count, not gated by inc; the caller decides
  // whether the wrap actually takes effect this cycle.
  assign wrap = w_atLast;
  assign cnt  = r_cnt;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Free-running VGA raster timing generator. Two modulo counters track the
//   raster position (h = pixel within line, v = line within frame); every
//   output is a pure decode of those two registers, so nothing combinational
//   reaches an output from ena. The raster advances one pixel per clock in
//   which ena is high, which lets the block run from a true pixel clock or a
//   faster clock with a divided enable.
//
// Parameters:
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines
//   SYNC_NEG                   1 = sync pulses active-low, 0 = active-high
//   CW                         counter width, 2^CW >= H_TOTAL and V_TOTAL
//
// Ports:
//   clk          in   clock (single domain)
//   rst_n        in   asynchronous active-low reset
//   ena          in   pixel-advance enable
//   hsync        out  horizontal sync, polarity per SYNC_NEG
//   vsync        out  vertical sync, polarity per SYNC_NEG
//   active       out  high inside the visible area
//   x            out  horizontal position, 0..H_TOTAL-1
//   y            out  vertical position, 0..V_TOTAL-1
//   line_start   out  level, high while x = 0
//   frame_start  out  level, high while x = 0 and y = 0
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_NEG = 1'b1,
  parameter int CW       = VGA_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are stored as inclusive first/last positions so that a
  // window ending on the final counter value cannot truncate to zero.
  localparam logic [CW-1:0] H_VIS_LAST   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_VIS_LAST   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] w_h;
  logic [CW-1:0] w_v;
  logic          w_hWrap;
  logic          w_vInc;
  logic          w_unusedVWrap;
  logic          w_hVisible;
  logic          w_vVisible;
  logic          w_hInSync;
  logic          w_vInSync;
  logic          w_hZero;
  logic          w_vZero;

  // Pixel counter: advances on every enabled clock.
  mod_counter #(
    .N (H_TOTAL),
    .W (CW)
  ) u_hCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ena),
    .wrap  (w_hWrap),
    .cnt   (w_h)
  );

  // Line counter: advances only on the enabled edge that wraps the pixel
  // counter, so (H_TOTAL-1, V_TOTAL-1) goes straight to (0, 0) in one edge.
  assign w_vInc = ena & w_hWrap;

  // The end of frame is already visible as frame_start on the following
  // cycle, so the line counter's own wrap flag has no consumer here.
  mod_counter #(
    .N (V_TOTAL),
    .W (CW)
  ) u_vCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_vInc),
    .wrap  (w_unusedVWrap),
    .cnt   (w_v)
  );

  // Visible area and sync windows, decoded from the registered counters only.
  assign w_hVisible = (w_h <= H_VIS_LAST);
  assign w_vVisible = (w_v <= V_VIS_LAST);
  assign w_hInSync  = (w_h >= H_SYNC_FIRST) && (w_h <= H_SYNC_LAST);
  assign w_vInSync  = (w_v >= V_SYNC_FIRST) && (w_v <= V_SYNC_LAST);
  assign w_hZero    = (w_h == '0);
  assign w_vZero    = (w_v == '0);

  assign hsync       = syncLevel(w_hInSync, SYNC_NEG);
  assign vsync       = syncLevel(w_vInSync, SYNC_NEG);
  assign active      = w_hVisible & w_vVisible;
  assign x           = w_h;
  assign y           = w_v;

  // Levels rather than strobes: they stay high for as long as ena holds the
  // raster at the origin, so consumers qualify them with ena.
  assign line_start  = w_hZero;
  assign frame_start = w_hZero & w_vZero;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator. Produces horizontal/vertical sync, the `active` display-enable and the current pixel coordinates. It is the upstream producer of the `active` qualifier consumed by `rgb_active`, which blanks the 6-bit RGB bus outside the visible area. It advances one pixel per clock when `ena` is high, so the same block serves a 25.175 MHz pixel clock or a faster clock with a divided enable.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `SYNC_NEG`, 1: 1 = sync pulses active-low (640x480 standard); 0 = active-high
- `CW`, 10: coordinate/counter width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL
- `clk`  in  1  clock; one clock domain only
- `rst_n`  in  1  reset; asynchronous, active-low
- `ena`  in  1  pixel-advance enable
- `hsync`  out  1  horizontal sync, polarity per `SYNC_NEG`
- `vsync`  out  1  vertical sync, polarity per `SYNC_NEG`
- `active`  out  1  high while the raster position is in the visible area
- `x`  out  CW  horizontal counter value, 0..H_TOTAL-1
- `y`  out  CW  vertical counter value, 0..V_TOTAL-1
- `line_start`  out  1  high while h = 0
- `frame_start`  out  1  high while h = 0 and v = 0

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- State consists of two registered counters, `h` and `v`. No other state.
- On a rising `clk` edge with `ena` = 1:
  - If h = H_TOTAL-1: h <= 0, and v advances.
  - Otherwise: h <= h+1.
- v advance: if v = V_TOTAL-1 then v <= 0, else v <= v+1. v changes only on the h wrap.
- With `ena` = 0, both counters hold.
- All outputs are pure decodes of the registered `h` and `v`. There is no combinational path from `ena` to any output.
  - `x` = h; `y` = v.
  - `active` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync pulse window: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync pulse window: v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - Output levels: `hsync`/`vsync` = window XOR `SYNC_NEG` for negative polarity; the inactive level is 1 when `SYNC_NEG` = 1.
- Counters never leave their legal ranges. Counter arithmetic is CW bits wide with explicit compare-and-wrap; it never relies on natural 2^CW overflow.

## Timing
- Reset, asynchronous and taking effect immediately (including mid-frame):
  - h = 0, v = 0, so `x` = 0 and `y` = 0.
  - `active` = 1.
  - `hsync` = `vsync` = inactive level.
  - `line_start` = 1, `frame_start` = 1.
- First `clk` edge after `rst_n` deasserts with `ena` = 1: x = 1.
- Output latency: every output reflects the counter state of the current cycle (zero cycles from the counter register).
- Downstream pixel logic registering on `ena` sees its data one pixel late. Compensating that pipeline delay is the consumer's responsibility.
- Line period is H_TOTAL enabled cycles. Frame period is H_TOTAL×V_TOTAL enabled cycles (420000).
- `line_start` and `frame_start` are levels, not one-cycle strobes. With `ena` low they remain high for multiple clocks; consumers qualify them with `ena`.
- Wrap boundary (h = 799, v = 524) with `ena` = 1: the next state is (0,0) in a single edge, with no intermediate value.

## Structure
- Shared package `vga_pkg` holds:
  - the 640x480@60 timing constants (active, porch and sync widths; totals);
  - the default coordinate width CW = 10.
- One sub-module, `mod_counter` (parameters N and W; ports `clk`, `rst_n`, `inc`, `wrap` out, `cnt` out), instantiated twice:
  - horizontal instance: `inc` = `ena`;
  - vertical instance: `inc` = `ena` && h-instance `wrap`.
- Sync and active decodes live in the top level.

## Test plan
- Reset: hold `rst_n` = 0 with `ena` = 1 -> x = 0, y = 0, active = 1, hsync = vsync = 1, line_start = frame_start = 1.
- One line, `ena` tied high: active falls when x = 640; hsync = 0 exactly for x = 656..751 (96 cycles); x wraps 799 -> 0; y increments 0 -> 1 on that edge.
- Full frame: vsync = 0 only for y = 490..491 (1600 cycles); after 420000 enabled cycles frame_start returns high with x = y = 0.
- `ena` gating: `ena` toggled every other clock -> one line spans 1600 clocks; counters hold while `ena` = 0; outputs stable across held cycles.
- Reset mid-frame at (x=300, y=200): assert `rst_n` = 0 asynchronously between edges -> outputs go to the reset values before the next edge; counting resumes from 0.
- Integration with `rgb_active` (all pixel inputs = 2'b11): vga_out = 6'b111111 when active = 1, and 6'b000000 at x = 700 and at y = 500.
